// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared types, delay marker and built-in sensor table for the camera init sequencer
package cam_cfg_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    localparam logic [15:0] DELAY_MARK = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWDN,
        ST_RST,
        ST_SETTLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } cam_init_state_t;

    localparam int DEFAULT_LEN = 33;

    // 1280x720 RGB565 bring-up: soft reset, PLL, window/output size, RGB565 format
    localparam logic [0:DEFAULT_LEN-1][23:0] DEFAULT_TABLE = {
        24'h310311, 24'h300882, 24'hFFFF01, 24'h300842, 24'h310303, 24'h3017FF,
        24'h3018FF, 24'h30341A, 24'h303521, 24'h303669, 24'h303713, 24'h310801,
        24'h382041, 24'h382107, 24'h380000, 24'h380100, 24'h380200, 24'h3803FA,
        24'h38040A, 24'h38053F, 24'h380606, 24'h3807A9, 24'h380805, 24'h380900,
        24'h380A02, 24'h380BD0, 24'h380C07, 24'h380D64, 24'h380E02, 24'h380FE4,
        24'h430061, 24'h501F01, 24'h300802
    };

    // Entries past the real table are zero-length delays, which walk by as no-ops
    function automatic cfg_entry_t default_entry(input int idx);
        return (idx < DEFAULT_LEN) ? cfg_entry_t'(DEFAULT_TABLE[6'(idx)]) : cfg_entry_t'({DELAY_MARK, 8'h00});
    endfunction

endpackage

// File: rtl/cam_init_sequencer_if.sv
// cam_init_sequencer_if: register-write request/completion handshake to the SCCB byte-write master
interface cam_init_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_nack;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready, wr_done, wr_nack);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready, wr_done, wr_nack);
endinterface

// File: rtl/cam_init_rom.sv
// cam_init_rom: synchronous-read register table, either caller-supplied or the built-in sensor table
module cam_init_rom
    import cam_cfg_pkg::*;
#(
    parameter int                        REG_COUNT = 256,
    parameter bit                        USE_TABLE = 1'b0,
    parameter logic [REG_COUNT*24-1:0]   TABLE     = '0,
    localparam int                       IW        = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic [IW-1:0] i_idx,
    output cfg_entry_t    o_entry
);

    cfg_entry_t r_entry;

    // Registered read: the entry for i_idx is presented one cycle later
    always_ff @(posedge clk) begin
        r_entry <= USE_TABLE ? cfg_entry_t'(TABLE[32'(i_idx) * 24 +: 24]) : default_entry(int'(i_idx));
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/cam_init_sequencer.sv
// cam_init_sequencer: sensor power-up timing, then register table walk over the SCCB write handshake
module cam_init_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int                      REG_COUNT  = 256,
    parameter int                      T_PWDN     = 100_000,
    parameter int                      T_RST      = 100_000,
    parameter int                      T_SETTLE   = 2_000_000,
    parameter int                      DELAY_UNIT = 100_000,
    parameter int                      TIMEOUT    = 1_000_000,
    parameter int                      MAX_RETRY  = 3,
    parameter int                      AUTO_START = 1,
    parameter bit                      USE_TABLE  = 1'b0,
    parameter logic [REG_COUNT*24-1:0] TABLE      = '0,
    localparam int                     IW         = $clog2(REG_COUNT),
    localparam int                     RW         = $clog2(MAX_RETRY + 2)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    output logic                        o_cam_pwdn,
    output logic                        o_cam_rst_n,
    cam_init_sequencer_if.master        bus,
    output logic                        o_busy,
    output logic                        o_cfg_done,
    output logic                        o_cfg_error,
    output logic [IW-1:0]               o_fail_index
);

    cam_init_state_t r_state, w_state_n;
    logic [31:0]     r_cnt, w_cnt_n;
    logic [IW-1:0]   r_idx, w_idx_n, r_fail, w_fail_n;
    logic [RW-1:0]   r_retry, w_retry_n;
    logic [15:0]     r_addr, w_addr_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_valid, r_pwdn, r_cam_rst_n, r_busy;
    logic            r_done, w_done_n, r_err, w_err_n;
    cfg_entry_t      w_entry;
    logic            w_last, w_adv;

    cam_init_rom #(
        .REG_COUNT (REG_COUNT),
        .USE_TABLE (USE_TABLE),
        .TABLE     (TABLE)
    ) u_rom (
        .clk     (clk),
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_last = r_idx == IW'(REG_COUNT - 1);
    assign w_adv  = (r_state == ST_WAIT && bus.wr_done && !bus.wr_nack) ||
                    (r_state == ST_DELAY && r_cnt <= 32'd1);

    // Next state, phase counter and table position; a finished write or delay advances the index
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_retry_n = r_retry;
        w_addr_n  = r_addr;
        w_data_n  = r_data;
        w_done_n  = r_done;
        w_err_n   = r_err;
        w_fail_n  = r_fail;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start || (r_state == ST_IDLE && AUTO_START != 0)) begin
                    w_state_n = ST_PWDN;
                    w_cnt_n   = '0;
                    w_done_n  = 1'b0;
                    w_err_n   = 1'b0;
                    w_fail_n  = '0;
                end
            end
            ST_PWDN: begin
                w_cnt_n = r_cnt + 32'd1;
                if (r_cnt == 32'(T_PWDN - 1)) begin
                    w_state_n = ST_RST;
                    w_cnt_n   = '0;
                end
            end
            ST_RST: begin
                w_cnt_n = r_cnt + 32'd1;
                if (r_cnt == 32'(T_RST - 1)) begin
                    w_state_n = ST_SETTLE;
                    w_cnt_n   = '0;
                end
            end
            ST_SETTLE: begin
                w_cnt_n = r_cnt + 32'd1;
                if (r_cnt == 32'(T_SETTLE - 1)) begin
                    w_state_n = ST_FETCH;
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_retry_n = '0;
                end
            end
            ST_FETCH: begin
                w_cnt_n = 32'd1;
                if (r_cnt != '0) begin
                    w_cnt_n = 32'(w_entry.data) * 32'(DELAY_UNIT);
                    if (w_entry.addr == DELAY_MARK) begin
                        w_state_n = ST_DELAY;
                    end else begin
                        w_state_n = ST_ISSUE;
                        w_addr_n  = w_entry.addr;
                        w_data_n  = w_entry.data;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.wr_ready) begin
                    w_state_n = ST_WAIT;
                    w_cnt_n   = 32'd1;
                end
            end
            ST_WAIT: begin
                w_cnt_n = r_cnt + 32'd1;
                if (bus.wr_done ? bus.wr_nack : (r_cnt == 32'(TIMEOUT - 1))) begin
                    if (r_retry == RW'(MAX_RETRY)) begin
                        w_state_n = ST_ERROR;
                        w_err_n   = 1'b1;
                        w_fail_n  = r_idx;
                    end else begin
                        w_state_n = ST_ISSUE;
                        w_retry_n = r_retry + 1'b1;
                    end
                end
            end
            ST_DELAY: w_cnt_n = r_cnt - 32'd1;
            default:  w_state_n = ST_IDLE;
        endcase
        if (w_adv) begin
            w_idx_n   = r_idx + 1'b1;
            w_retry_n = '0;
            w_cnt_n   = '0;
            w_state_n = w_last ? ST_DONE : ST_FETCH;
            w_done_n  = w_last;
        end
    end

    // State register; pins and status are decoded from the next state so every output is registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_pwdn      <= 1'b1;
            r_cam_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fail      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_idx       <= w_idx_n;
            r_retry     <= w_retry_n;
            r_addr      <= w_addr_n;
            r_data      <= w_data_n;
            r_valid     <= w_state_n == ST_ISSUE;
            r_pwdn      <= w_state_n == ST_IDLE || w_state_n == ST_PWDN;
            r_cam_rst_n <= !(w_state_n == ST_IDLE || w_state_n == ST_PWDN || w_state_n == ST_RST);
            r_busy      <= !(w_state_n == ST_IDLE || w_state_n == ST_DONE || w_state_n == ST_ERROR);
            r_done      <= w_done_n;
            r_err       <= w_err_n;
            r_fail      <= w_fail_n;
        end
    end

    assign bus.wr_valid = r_valid;
    assign bus.wr_addr  = r_addr;
    assign bus.wr_data  = r_data;
    assign o_cam_pwdn   = r_pwdn;
    assign o_cam_rst_n  = r_cam_rst_n;
    assign o_busy       = r_busy;
    assign o_cfg_done   = r_done;
    assign o_cfg_error  = r_err;
    assign o_fail_index = r_fail;

endmodule
